// File: rtl/regfile_sb32.sv
// 32 x 32-bit register file with one write port, two combinational read ports,
// r0 hardwired to zero, and a per-register pending-write scoreboard.
// Optional same-cycle write-to-read forwarding: define REGFILE_SB_BYPASS_EN.
`timescale 1ns/1ps

module regfile_sb32 #(
    parameter int NREG = 32,
    parameter int AW   = 5,
    parameter int DW   = 32
) (
    input  logic          Clk,
    input  logic          Clr,
    input  logic [AW-1:0] Rna,
    input  logic [AW-1:0] Rnb,
    output logic [DW-1:0] Qa,
    output logic [DW-1:0] Qb,
    input  logic          We,
    input  logic [AW-1:0] Wn,
    input  logic [DW-1:0] D,
    input  logic          Iss,
    input  logic [AW-1:0] Iss_rd,
    output logic          Busy_a,
    output logic          Busy_b,
    output logic [AW:0]   Busy_cnt
);

    logic [DW-1:0]   regs_r [NREG];
    logic [NREG-1:0] busy_r;
    logic [AW:0]     busy_cnt_r;

    logic            wr_en_s;
    logic            iss_en_s;
    logic [NREG-1:0] busy_nxt_s;
    logic [DW-1:0]   rd_a_s;
    logic [DW-1:0]   rd_b_s;
    logic            byp_a_s;
    logic            byp_b_s;

    function automatic logic [AW:0] popcount(input logic [NREG-1:0] v);
        logic [AW:0] cnt;
        cnt = {(AW+1){1'b0}};
        for (int i = 0; i < NREG; i++) begin
            cnt = cnt + {{AW{1'b0}}, v[i]};
        end
        return cnt;
    endfunction

    assign wr_en_s  = We  && (Wn     != {AW{1'b0}});
    assign iss_en_s = Iss && (Iss_rd != {AW{1'b0}});

    // Next scoreboard state: a new issue beats a same-cycle write-back to the same index.
    always_comb begin
        busy_nxt_s = {NREG{1'b0}};
        for (int i = 1; i < NREG; i++) begin
            busy_nxt_s[i] = (iss_en_s && (Iss_rd == AW'(i)))
                          | (busy_r[i] & ~(wr_en_s && (Wn == AW'(i))));
        end
    end

    // Register array, busy bits and registered population count.
    always_ff @(posedge Clk) begin
        if (Clr) begin
            for (int i = 0; i < NREG; i++) begin
                regs_r[i] <= {DW{1'b0}};
            end
            busy_r     <= {NREG{1'b0}};
            busy_cnt_r <= {(AW+1){1'b0}};
        end else begin
            if (wr_en_s) begin
                regs_r[Wn] <= D;
            end
            busy_r     <= busy_nxt_s;
            busy_cnt_r <= popcount(busy_nxt_s);
        end
    end

    // Stored-value reads; index 0 is forced to zero independent of array contents.
    always_comb begin
        rd_a_s = regs_r[Rna];
        rd_b_s = regs_r[Rnb];
        if (Rna == {AW{1'b0}}) begin
            rd_a_s = {DW{1'b0}};
        end else begin
            rd_a_s = regs_r[Rna];
        end
        if (Rnb == {AW{1'b0}}) begin
            rd_b_s = {DW{1'b0}};
        end else begin
            rd_b_s = regs_r[Rnb];
        end
    end

`ifdef REGFILE_SB_BYPASS_EN
    assign byp_a_s = wr_en_s && (Wn == Rna);
    assign byp_b_s = wr_en_s && (Wn == Rnb);
`else
    assign byp_a_s = 1'b0;
    assign byp_b_s = 1'b0;
`endif

    // A forwarded read is busy only if the same index is being reissued this cycle.
    assign Qa       = byp_a_s ? D : rd_a_s;
    assign Qb       = byp_b_s ? D : rd_b_s;
    assign Busy_a   = byp_a_s ? (iss_en_s && (Iss_rd == Rna)) : busy_r[Rna];
    assign Busy_b   = byp_b_s ? (iss_en_s && (Iss_rd == Rnb)) : busy_r[Rnb];
    assign Busy_cnt = busy_cnt_r;

endmodule
